pc_sequencer: RTL

Next-PC controller for the 32-bit MIPS-style processor. It owns the fetch PC register and sequences the branch/jump target datapath: PC+4, sign-extended and shifted-left-2 branch offset, pseudo-direct jump target, and optional jump-register target. It tracks the PC of the instruction in decode, resolves control-flow changes for that instruction, and squashes the wrong-path fetch on every redirect. It sits between instruction memory and the decode/control unit.

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, tracks the decode PC and resolves branch/jump redirects.
// Define PC_SEQ_JR_EN to build the jump-register path and its AlignErr pulse.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic        Zero,
  input  logic [15:0] Imm16,
  input  logic        Jump,
  input  logic [25:0] JumpAddr26,
  input  logic        JumpReg,
  input  logic [31:0] RegAddr,
  output logic [31:0] PC,
  output logic        FetchValid,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        DecValid,
  output logic        Flush,
  output logic        AlignErr
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4d_q, pcp4d_d;
  logic        dec_valid_q, dec_valid_d;

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        taken;
  logic        resolve;
  logic        redirect;
  logic        align_err;

  assign seq_pc    = pc_q + 32'd4;
  assign br_target = pcp4d_q + {{14{Imm16[15]}}, Imm16, 2'b00};
  assign j_target  = {pcp4d_q[31:28], JumpAddr26, 2'b00};
  assign taken     = Branch & (Zero ^ BranchNE);
  // Only a live, unstalled decode instruction may redirect; DecValid is 0 in BOOT and REDIRECT.
  assign resolve   = dec_valid_q & ~Stall;

`ifndef PC_SEQ_JR_EN
  logic unused_jr;
  assign unused_jr = ^{JumpReg, RegAddr};
`endif

  always_comb begin
    redirect  = 1'b0;
    align_err = 1'b0;
    target    = seq_pc;
    if (resolve) begin
`ifdef PC_SEQ_JR_EN
      if (JumpReg) begin
        redirect  = 1'b1;
        target    = {RegAddr[31:2], 2'b00};
        align_err = |RegAddr[1:0];
      end else
`endif
      if (Jump) begin
        redirect = 1'b1;
        target   = j_target;
      end else if (taken) begin
        redirect = 1'b1;
        target   = br_target;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pcd_d       = pcd_q;
    pcp4d_d     = pcp4d_q;
    dec_valid_d = dec_valid_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, REDIRECT: begin
        if (!Stall) begin
          pcd_d       = pc_q;
          pcp4d_d     = seq_pc;
          pc_d        = target;
          dec_valid_d = ~redirect;
          state_d     = redirect ? REDIRECT : RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pcd_q       <= '0;
      pcp4d_q     <= 32'd4;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pcd_q       <= pcd_d;
      pcp4d_q     <= pcp4d_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign PC         = pc_q;
  assign FetchValid = (state_q != BOOT);
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcp4d_q;
  assign DecValid   = dec_valid_q;
  assign Flush      = redirect;
  assign AlignErr   = align_err;

endmodule
